// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed load/store requests into
// doubleword memory accesses with read-modify-write for narrow stores.
module load_store_unit #(
    parameter int DEPTH = 128,
    parameter int IDX_W = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic [63:0] mem_read_addr,
    input  logic [63:0] mem_read_data,
    output logic        mem_write,
    output logic [63:0] mem_write_addr,
    output logic [63:0] mem_write_data
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_e;

    function automatic logic [2:0] span(input logic [1:0] size);
        logic [2:0] s;
        unique case (size)
            2'd0:    s = 3'd0;
            2'd1:    s = 3'd1;
            2'd2:    s = 3'd3;
            default: s = 3'd7;
        endcase
        return s;
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        logic [63:0] m;
        unique case (size)
            2'd0:    m = 64'h0000_0000_0000_00FF;
            2'd1:    m = 64'h0000_0000_0000_FFFF;
            2'd2:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return m;
    endfunction

    // Big-endian: the lowest offset of the field lands in the top byte.
    function automatic logic [5:0] lane_shift(input logic [2:0] off,
                                              input logic [1:0] size);
        logic [2:0] lo;
        lo = 3'd7 - off - span(size);
        return {lo, 3'b000};
    endfunction

    state_e state_q, state_d;

    logic             store_q, store_d;
    logic [1:0]       size_q, size_d;
    logic             signed_q, signed_d;
    logic [2:0]       off_q, off_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [63:0]      wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        mem_read_q, mem_read_d;
    logic [63:0] mem_read_addr_q, mem_read_addr_d;
    logic        mem_write_q, mem_write_d;
    logic [63:0] mem_write_addr_q, mem_write_addr_d;
    logic [63:0] mem_write_data_q, mem_write_data_d;

    logic        req_mis;
    logic        req_oor;
    logic [5:0]  lane_sh;
    logic [63:0] lane_m;
    logic [63:0] rd_lane;
    logic [63:0] rd_ext;
    logic [63:0] merged;
    logic [63:0] idx_ext;

    assign req_mis = |(req_addr[2:0] & span(req_size));
    assign req_oor = req_addr[63:3] >= 61'(DEPTH);

    assign lane_sh = lane_shift(off_q, size_q);
    assign lane_m  = lane_mask(size_q);
    assign rd_lane = (mem_read_data >> lane_sh) & lane_m;
    assign merged  = (mem_read_data & ~(lane_m << lane_sh))
                   | ((wdata_q & lane_m) << lane_sh);

    always_comb begin
        rd_ext = rd_lane;
        if (signed_q) begin
            unique case (size_q)
                2'd1:    rd_ext = {{48{rd_lane[15]}}, rd_lane[15:0]};
                2'd2:    rd_ext = {{32{rd_lane[31]}}, rd_lane[31:0]};
                default: rd_ext = rd_lane;
            endcase
        end
    end

    always_comb begin
        state_d          = state_q;
        store_d          = store_q;
        size_d           = size_q;
        signed_d         = signed_q;
        off_d            = off_q;
        idx_d            = idx_q;
        wdata_d          = wdata_q;
        resp_valid_d     = resp_valid_q;
        resp_err_d       = resp_err_q;
        resp_rdata_d     = resp_rdata_q;
        mem_write_data_d = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    size_d   = req_size;
                    signed_d = req_signed;
                    off_d    = req_addr[2:0];
                    idx_d    = req_addr[3+IDX_W-1:3];
                    wdata_d  = req_wdata;
                    if (req_mis || req_oor) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (req_store && req_size == 2'd3) begin
                        state_d          = WR;
                        mem_write_data_d = req_wdata;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (store_q) begin
                    state_d          = WR;
                    mem_write_data_d = merged;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = rd_ext;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        idx_ext          = {{(64-IDX_W){1'b0}}, idx_d};
        req_ready_d      = (state_d == IDLE);
        mem_read_d       = (state_d == RD);
        mem_read_addr_d  = (state_d == RD) ? idx_ext : '0;
        mem_write_d      = (state_d == WR);
        mem_write_addr_d = (state_d == WR) ? idx_ext : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            store_q          <= 1'b0;
            size_q           <= '0;
            signed_q         <= 1'b0;
            off_q            <= '0;
            idx_q            <= '0;
            wdata_q          <= '0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= '0;
            mem_read_q       <= 1'b0;
            mem_read_addr_q  <= '0;
            mem_write_q      <= 1'b0;
            mem_write_addr_q <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            store_q          <= store_d;
            size_q           <= size_d;
            signed_q         <= signed_d;
            off_q            <= off_d;
            idx_q            <= idx_d;
            wdata_q          <= wdata_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
            mem_read_q       <= mem_read_d;
            mem_read_addr_q  <= mem_read_addr_d;
            mem_write_q      <= mem_write_d;
            mem_write_addr_q <= mem_write_addr_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_read       = mem_read_q;
    assign mem_read_addr  = mem_read_addr_q;
    assign mem_write      = mem_write_q;
    assign mem_write_addr = mem_write_addr_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a behavioural
// 128-doubleword memory attached.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic [63:0] mem_read_addr;
    logic [63:0] mem_read_data;
    logic        mem_write;
    logic [63:0] mem_write_addr;
    logic [63:0] mem_write_data;

    logic [63:0] mem [0:127];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(128), .IDX_W(7)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_store(req_store),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_read(mem_read),
        .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .mem_write(mem_write),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data)
    );

    assign mem_read_data = mem[mem_read_addr[6:0]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_write_addr[6:0]] = mem_write_data;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Issues one request and returns once resp_valid is seen (or a timeout).
    task automatic issue(input logic st, input logic [1:0] sz,
                         input logic sg, input logic [63:0] a,
                         input logic [63:0] wd, output int lat,
                         output int nrd, output int nwr,
                         output logic [63:0] ra, output logic [63:0] wa,
                         output int both);
        lat  = 0;
        nrd  = 0;
        nwr  = 0;
        both = 0;
        ra   = '0;
        wa   = '0;
        @(negedge clk);
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (mem_read) begin
                nrd++;
                ra = mem_read_addr;
            end
            if (mem_write) begin
                nwr++;
                wa = mem_write_addr;
            end
            if (mem_read && mem_write) both++;
            if (resp_valid) break;
        end
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("req_ready_after_resp", 64'(req_ready), 64'd1);
    endtask

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        sg;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] pre;
        logic [63:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [63:0] exp_mem;
    } vec_t;

    localparam logic [63:0] A = 64'h1122_3344_5566_7788;
    localparam logic [63:0] B = 64'h80FF_0000_0000_0000;

    vec_t vt[15];

    initial begin
        int          lat, nrd, nwr, both;
        logic [63:0] ra, wa, idx, snap;
        logic        seen;

        vt[0]  = '{1'b0, 2'd3, 1'b0, 64'h8, 64'h0, A, A, 1'b0, 2, A};
        vt[1]  = '{1'b0, 2'd0, 1'b0, 64'hB, 64'h0, A, 64'h44, 1'b0, 2, A};
        vt[2]  = '{1'b0, 2'd1, 1'b1, 64'hE, 64'h0, A, 64'h7788, 1'b0, 2, A};
        vt[3]  = '{1'b0, 2'd1, 1'b1, 64'h8, 64'h0, B,
                   64'hFFFF_FFFF_FFFF_80FF, 1'b0, 2, B};
        vt[4]  = '{1'b0, 2'd2, 1'b0, 64'h8, 64'h0, B,
                   64'h0000_0000_80FF_0000, 1'b0, 2, B};
        vt[5]  = '{1'b0, 2'd2, 1'b1, 64'h8, 64'h0, B,
                   64'hFFFF_FFFF_80FF_0000, 1'b0, 2, B};
        vt[6]  = '{1'b0, 2'd0, 1'b1, 64'h8, 64'h0, B, 64'h80, 1'b0, 2, B};
        vt[7]  = '{1'b1, 2'd0, 1'b0, 64'h9, 64'hAB, A, 64'h0, 1'b0, 3,
                   64'h11AB_3344_5566_7788};
        vt[8]  = '{1'b1, 2'd1, 1'b0, 64'hC, 64'hFFFF_BEEF, A, 64'h0, 1'b0, 3,
                   64'h1122_3344_BEEF_7788};
        vt[9]  = '{1'b1, 2'd2, 1'b0, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,
                   64'h0, 1'b0, 3, 64'hCAFE_F00D_0000_0000};
        vt[10] = '{1'b1, 2'd3, 1'b0, 64'h3F8, 64'h0123_4567_89AB_CDEF, A,
                   64'h0, 1'b0, 2, 64'h0123_4567_89AB_CDEF};
        vt[11] = '{1'b0, 2'd2, 1'b0, 64'h6, 64'h0, 64'h0, 64'h0, 1'b1, 1, 64'h0};
        vt[12] = '{1'b1, 2'd3, 1'b0, 64'h400, 64'h55, 64'h0, 64'h0, 1'b1, 1,
                   64'h0};
        vt[13] = '{1'b0, 2'd1, 1'b0, 64'h9, 64'h0, 64'h0, 64'h0, 1'b1, 1, 64'h0};
        vt[14] = '{1'b0, 2'd3, 1'b0, 64'h8000_0000_0000_0008, 64'h0, 64'h0,
                   64'h0, 1'b1, 1, 64'h0};

        for (int i = 0; i < 128; i++) mem[i] = 64'(i) * 64'h0101_0101;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_rd_addr", mem_read_addr, 64'd0);
        chk("rst_wr_data", mem_write_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            idx = {54'd0, vt[i].addr[12:3]};
            if (!vt[i].exp_err) mem[idx[6:0]] = vt[i].pre;
            issue(vt[i].st, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd,
                  lat, nrd, nwr, ra, wa, both);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].exp_lat));
            chk($sformatf("v%0d_err", i), 64'(resp_err), 64'(vt[i].exp_err));
            chk($sformatf("v%0d_rdata", i), resp_rdata, vt[i].exp_rd);
            chk($sformatf("v%0d_both", i), 64'(both), 64'd0);
            chk($sformatf("v%0d_nwr", i), 64'(nwr),
                64'(vt[i].st && !vt[i].exp_err));
            chk($sformatf("v%0d_nrd", i), 64'(nrd),
                64'(!vt[i].exp_err && !(vt[i].st && vt[i].sz == 2'd3)));
            if (nrd > 0) chk($sformatf("v%0d_raddr", i), ra, idx);
            if (nwr > 0) chk($sformatf("v%0d_waddr", i), wa, idx);
            if (vt[i].st && !vt[i].exp_err)
                chk($sformatf("v%0d_mem", i), mem[idx[6:0]], vt[i].exp_mem);
            consume();
        end

        // Narrow store followed by a load of the same doubleword.
        mem[1] = A;
        issue(1'b1, 2'd0, 1'b0, 64'h9, 64'hAB, lat, nrd, nwr, ra, wa, both);
        chk("seq_stb_lat", 64'(lat), 64'd3);
        consume();
        issue(1'b1, 2'd1, 1'b0, 64'hE, 64'h1234, lat, nrd, nwr, ra, wa, both);
        consume();
        issue(1'b0, 2'd3, 1'b0, 64'h8, 64'h0, lat, nrd, nwr, ra, wa, both);
        chk("seq_ld_after_st", resp_rdata, 64'h11AB_3344_5566_1234);
        consume();

        // Backpressure on the response.
        mem[1] = A;
        issue(1'b0, 2'd2, 1'b0, 64'hC, 64'h0, lat, nrd, nwr, ra, wa, both);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_rdata", resp_rdata, 64'h5566_7788);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("bp_release_ready", 64'(req_ready), 64'd1);
        chk("bp_release_valid", 64'(resp_valid), 64'd0);

        // Reset in the middle of a read-modify-write store.
        mem[3] = A;
        seen   = 1'b0;
        @(negedge clk);
        req_store  = 1'b1;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 64'h18;
        req_wdata  = 64'hCD;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_write) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_wr_seen", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_drop", 64'(mem_write), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem", mem[3], A);
        chk("rst_mid_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_valid", 64'(resp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the data memory.
- Converts byte-addressed uPOWER load/store requests from the execute stage into doubleword-indexed memory accesses: lbz/lhz/lha/lwz/lwa/ld and stb/sth/stw/std.
- Sub-doubleword stores use a read-modify-write sequence.
- Loads are extracted and extended; misaligned or out-of-range requests are rejected with an error response.

Parameters:
DEPTH, 128, number of 64-bit doublewords in the data memory; valid index range 0..DEPTH-1
IDX_W, 7, width of the doubleword index, equal to clog2(DEPTH)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous and active-low
req_valid  input  1  execute stage presents a request
req_ready  output  1  unit can accept a request
req_store  input  1  1 = store, 0 = load
req_size  input  2  access size: 0 byte, 1 halfword, 2 word, 3 doubleword
req_signed  input  1  sign-extend load result (lha, lwa); ignored for stores and doublewords
req_addr  input  64  byte effective address
req_wdata  input  64  store data, right-justified
resp_valid  output  1  response available
resp_ready  input  1  writeback stage consumes the response
resp_rdata  output  64  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or out-of-range request
mem_read  output  1  drives the memory MemRead input
mem_read_addr  output  64  doubleword index, zero-extended
mem_read_data  input  64  combinational read data from memory
mem_write  output  1  drives the memory MemWrite input
mem_write_addr  output  64  doubleword index, zero-extended
mem_write_data  output  64  merged doubleword to write

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; resp_valid, resp_err, mem_read, mem_write=0; all address and data outputs=0. Reset mid-operation aborts the operation, drops mem_write immediately and discards any response.
- Addressing: idx = req_addr[3+IDX_W-1:3]; off = req_addr[2:0].
- Byte order is big-endian: off 0 maps to bits [63:56], off 7 to bits [7:0].
- Error when the request is misaligned: off mod (1<<req_size) != 0.
- Error when the request is out of range: req_addr[63:3] >= DEPTH.
- FSM states: IDLE, RD, WR, RESP. All outputs are registered. req_ready=1 only in IDLE.
- IDLE: on req_valid&&req_ready, latch the request.
  - Error -> RESP with resp_err=1 and no memory access.
  - Otherwise -> RD.
- RD: mem_read=1, mem_read_addr=idx; capture mem_read_data at the cycle end.
  - Load -> RESP.
  - Store of size 3 skips the read: mem_read=0 and the FSM goes straight to WR from IDLE.
  - Store of size 0..2 -> WR.
- WR: mem_write=1, mem_write_addr=idx. mem_write_data is the captured doubleword with the addressed lanes replaced by the low (8<<size) bits of req_wdata; size 3 writes req_wdata whole. Memory commits at the rising edge ending WR -> RESP.
- Load data: take the addressed lanes, right-justify, then zero-extend, or sign-extend when req_signed=1 and size is 1 or 2. lbz is never signed.
- RESP: resp_valid=1 and held, with resp_rdata/resp_err stable, until resp_ready=1. -> IDLE on the same edge; the next request is accepted one cycle later.
- Latency from the accept edge to resp_valid:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - Doubleword store: 2 cycles.
  - Sub-doubleword store: 3 cycles.
- mem_read and mem_write are never both asserted. mem_write is asserted for exactly one cycle per store.
- A store of size 0..2 whose index equals the previous store's index reads the already-committed value; no forwarding is needed.

Test Plan:
- Reset mid-store: assert rst_n=0 during WR -> mem_write=0 at once; doubleword unchanged; req_ready=1 and resp_valid=0 after release.
- ld at addr 0x8, memory[1]=0x1122334455667788 -> mem_read with mem_read_addr=1; resp_rdata=0x1122334455667788 two cycles after accept; resp_err=0.
- Byte/half/word loads with memory[1]=0x1122334455667788:
  - lbz addr 0xB -> 0x44.
  - lha addr 0xE, with bytes 0x77,0x88 -> 0x7788.
  - memory[1]=0x80FF000000000000, lha addr 0x8 -> 0xFFFFFFFFFFFF80FF.
  - lwz addr 0x8 -> 0x0000000080FF0000.
- stb addr 0x9, req_wdata=0xAB, memory[1]=0x1122334455667788 -> single-cycle write of 0x11AB334455667788 to index 1; resp after 3 cycles; a following ld returns the new value.
- Error requests, each -> resp_err=1 one cycle after accept, no mem_read/mem_write pulse, resp_rdata=0:
  - lwz addr 0x6 (misaligned).
  - std addr 0x400 with DEPTH=128 (out of range).
- Backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable and req_ready=0 throughout; one cycle after resp_ready=1, req_ready=1.
